// File: rtl/pattern_resp_compactor_pkg.sv
// -----------------------------------------------------------------------------
// pattern_resp_pkg
//   Shared types, default constants and the MISR next-state function for the
//   pattern response compactor.
//
//   Contents:
//     state_t         : compactor FSM states (IDLE, ACCUM, HOLD)
//     *_DEF           : default widths / polynomial / seed / window length
//     CNT_W, CHG_W    : sample counter and change counter widths
//     misr_next()     : one MISR step on vectors up to 32 bits wide
// -----------------------------------------------------------------------------
package pattern_resp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int          RESP_W_DEF     = 8;
  localparam int          SIG_W_DEF      = 16;
  localparam logic [15:0] POLY_DEF       = 16'h1021;
  localparam logic [15:0] SEED_DEF       = 16'hFFFF;
  localparam int          WINDOW_LEN_DEF = 64;

  localparam int CNT_W = 16;
  localparam int CHG_W = 8;

  // One MISR step on a w-bit signature held in the low bits of a 32-bit
  // container: shift left, fold the polynomial in when the outgoing MSB is
  // set, then XOR the zero-extended response sample. Bits above w are zero.
  function automatic logic [31:0] misr_next(
    input logic [31:0] cur,
    input logic [31:0] poly,
    input logic [31:0] data,
    input int          w
  );
    logic [31:0] mask;
    logic [31:0] nxt;
    mask = 32'hFFFF_FFFF >> (32 - w);
    nxt  = (cur << 1) & mask;
    if (((cur >> (w - 1)) & 32'd1) != 32'd0) begin
      nxt = nxt ^ (poly & mask);
    end
    nxt = nxt ^ (data & mask);
    return nxt;
  endfunction

endpackage

// File: rtl/pattern_resp_compactor_if.sv
// -----------------------------------------------------------------------------
// pattern_resp_if
//   Bundles the response input side and the signature handshake side of the
//   compactor.
//
//   Handshake: sig_valid rises with sig_data/sig_count already stable; they
//   stay stable while sig_valid=1 and sig_ready=0. A transfer happens on a
//   clock edge where sig_valid && sig_ready. sig_valid never drops without a
//   transfer except on reset. resp_vec is consumed on any edge where
//   resp_valid=1 (no backpressure toward the netlist).
//
//   Signals:
//     start        : begin / restart a window
//     resp_vec     : response sample
//     resp_valid   : resp_vec valid this cycle
//     sig_data     : captured signature
//     sig_count    : samples absorbed into sig_data
//     sig_valid    : signature available
//     sig_ready    : collector accepts signature
//     busy         : window in progress
//     resp_dropped : sticky, sample arrived while not accumulating
//
//   Modports: master = stimulus / collector side, slave = compactor.
// -----------------------------------------------------------------------------
interface pattern_resp_if #(
  parameter int RESP_W = pattern_resp_pkg::RESP_W_DEF,
  parameter int SIG_W  = pattern_resp_pkg::SIG_W_DEF
);

  logic                               start;
  logic [RESP_W-1:0]                  resp_vec;
  logic                               resp_valid;
  logic [SIG_W-1:0]                   sig_data;
  logic [pattern_resp_pkg::CNT_W-1:0] sig_count;
  logic                               sig_valid;
  logic                               sig_ready;
  logic                               busy;
  logic                               resp_dropped;

  modport master (
    output start, resp_vec, resp_valid, sig_ready,
    input  sig_data, sig_count, sig_valid, busy, resp_dropped
  );

  modport slave (
    input  start, resp_vec, resp_valid, sig_ready,
    output sig_data, sig_count, sig_valid, busy, resp_dropped
  );

endinterface

// File: rtl/pattern_resp_compactor_misr.sv
// -----------------------------------------------------------------------------
// pattern_resp_misr
//   Signature register plus single-step MISR update.
//
//   Ports:
//     clk         : clock, rising edge
//     rst         : synchronous active-high reset (register -> SEED)
//     i_load_seed : reload SEED (wins over i_step)
//     i_step      : absorb i_data this cycle
//     i_data      : response sample, zero-extended into the signature
//     o_value     : current signature
//     o_next      : signature after absorbing i_data (lookahead for capture)
// -----------------------------------------------------------------------------
module pattern_resp_misr
  import pattern_resp_pkg::*;
#(
  parameter int               RESP_W = RESP_W_DEF,
  parameter int               SIG_W  = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED   = SIG_W'(SEED_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load_seed,
  input  logic              i_step,
  input  logic [RESP_W-1:0] i_data,
  output logic [SIG_W-1:0]  o_value,
  output logic [SIG_W-1:0]  o_next
);

  logic [SIG_W-1:0] r_misr;
  logic [31:0]      w_next32;

  assign w_next32 = misr_next(32'(r_misr), 32'(POLY), 32'(i_data), SIG_W);
  assign o_next   = w_next32[SIG_W-1:0];
  assign o_value  = r_misr;

  if (SIG_W < 32) begin : g_hi
    logic w_unused_hi;
    assign w_unused_hi = ^w_next32[31:SIG_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_misr <= SEED;
    end else if (i_load_seed) begin
      r_misr <= SEED;
    end else if (i_step) begin
      r_misr <= o_next;
    end
  end

endmodule

// File: rtl/pattern_resp_compactor.sv
// -----------------------------------------------------------------------------
// pattern_resp_compactor
//   Compacts a window of WINDOW_LEN response samples into a MISR signature and
//   offers it to the collector with a valid/ready handshake.
//
//   Ports:
//     blif_clk_net   : clock, rising edge
//     blif_reset_net : synchronous active-high reset, overrides all inputs
//     bus            : pattern_resp_if.slave (start, resp_vec, resp_valid,
//                      sig_data, sig_count, sig_valid, sig_ready, busy,
//                      resp_dropped)
//     o_state        : FSM state, for observation
//     o_misr         : running signature, for observation
//     chg_cnt        : (RESP_CHG_CNT_EN only) count of absorbed samples that
//                      differ from the previous one, saturating at 255
//
//   Build option: define RESP_CHG_CNT_EN to add the chg_cnt output and its
//   counter; otherwise that port and logic are absent.
// -----------------------------------------------------------------------------
module pattern_resp_compactor
  import pattern_resp_pkg::*;
#(
  parameter int               RESP_W     = RESP_W_DEF,
  parameter int               SIG_W      = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY       = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED       = SIG_W'(SEED_DEF),
  parameter int               WINDOW_LEN = WINDOW_LEN_DEF
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  pattern_resp_if.slave    bus,
  output state_t           o_state,
  output logic [SIG_W-1:0] o_misr
`ifdef RESP_CHG_CNT_EN
  ,
  output logic [CHG_W-1:0] chg_cnt
`endif
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW_LEN - 1);
  localparam logic [CNT_W-1:0] WIN_CNT  = CNT_W'(WINDOW_LEN);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_load_seed;
  logic             w_step;
  logic             w_capture;
  logic [SIG_W-1:0] w_misr_next;
  logic [SIG_W-1:0] r_sig_data;
  logic [CNT_W-1:0] r_sig_count;
  logic             r_resp_dropped;

  pattern_resp_misr #(
    .RESP_W (RESP_W),
    .SIG_W  (SIG_W),
    .POLY   (POLY),
    .SEED   (SEED)
  ) u_misr (
    .clk         (blif_clk_net),
    .rst         (blif_reset_net),
    .i_load_seed (w_load_seed),
    .i_step      (w_step),
    .i_data      (bus.resp_vec),
    .o_value     (o_misr),
    .o_next      (w_misr_next)
  );

  // Next-state logic. start always reseeds (entering or restarting a window)
  // and takes priority over a coincident sample, which is discarded.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load_seed = 1'b0;
    w_step      = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = ACCUM;
          w_load_seed = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      ACCUM: begin
        if (bus.start) begin
          w_load_seed = 1'b1;
          w_cnt_nxt   = '0;
        end else if (bus.resp_valid) begin
          w_step    = 1'b1;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == LAST_IDX) begin
            w_capture   = 1'b1;
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        // start without sig_ready is ignored so the held signature survives.
        if (bus.sig_ready) begin
          if (bus.start) begin
            w_state_nxt = ACCUM;
            w_load_seed = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_sig_data     <= '0;
      r_sig_count    <= '0;
      r_resp_dropped <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_sig_data  <= w_misr_next;
        r_sig_count <= WIN_CNT;
      end
      if (bus.resp_valid && (r_state != ACCUM)) begin
        r_resp_dropped <= 1'b1;
      end
    end
  end

  assign bus.sig_data     = r_sig_data;
  assign bus.sig_count    = r_sig_count;
  assign bus.sig_valid    = (r_state == HOLD);
  assign bus.busy         = (r_state == ACCUM);
  assign bus.resp_dropped = r_resp_dropped;
  assign o_state          = r_state;

`ifdef RESP_CHG_CNT_EN
  logic [RESP_W-1:0] r_prev_resp;
  logic [CHG_W-1:0]  r_chg_run;
  logic [CHG_W-1:0]  r_chg_cnt;
  logic [CHG_W-1:0]  w_chg_run_nxt;

  // r_prev_resp starts each window at 0, so the first sample counts as a
  // change whenever it is non-zero.
  always_comb begin
    w_chg_run_nxt = r_chg_run;
    if ((bus.resp_vec != r_prev_resp) && (r_chg_run != {CHG_W{1'b1}})) begin
      w_chg_run_nxt = r_chg_run + CHG_W'(1);
    end
  end

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      r_prev_resp <= '0;
      r_chg_run   <= '0;
      r_chg_cnt   <= '0;
    end else if (w_load_seed) begin
      r_prev_resp <= '0;
      r_chg_run   <= '0;
      r_chg_cnt   <= '0;
    end else if (w_step) begin
      r_prev_resp <= bus.resp_vec;
      r_chg_run   <= w_chg_run_nxt;
      if (w_capture) begin
        r_chg_cnt <= w_chg_run_nxt;
      end
    end
  end

  assign chg_cnt = r_chg_cnt;
`endif

endmodule
